// File: rtl/apb_mst_bridge.sv
// ---------------------------------------------------------------------------
// apb_mst_bridge
//
// APB3 initiator. Converts a single-outstanding request/acknowledge handshake
// into an APB SETUP + ACCESS transfer, waits for PREADY and returns read data
// and the slave error flag on the acknowledge channel.
//
// Build option:
//   APB_MST_BRIDGE_TIMEOUT_EN - when defined, a watchdog aborts any ACCESS
//   phase that sees PREADY low for TIMECNT sampled cycles. The aborted
//   transfer completes with ack_err=1 and ack_rd_data=dead_1eaf, and the
//   sticky interrupt / to_addr pair records the event until 'clear'.
//   When undefined, ACCESS waits forever and interrupt/to_addr read 0.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   req_vld/req_rdy           request handshake (req_addr, req_write,
//                             req_wr_data)
//   ack_vld/ack_rdy           response handshake (ack_rd_data, ack_err)
//   PADDR..PSLVERR            APB3 initiator port
//   clear                     clears interrupt and to_addr
//   interrupt, to_addr        sticky timeout flag and address of the last
//                             timed-out transfer
// ---------------------------------------------------------------------------
module apb_mst_bridge #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 32,
   parameter int TIMECNT    = 99
) (
   input  logic                  clk,
   input  logic                  rstn,
   // request channel
   input  logic                  req_vld,
   output logic                  req_rdy,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic                  req_write,
   input  logic [DATA_WIDTH-1:0] req_wr_data,
   // acknowledge channel
   output logic                  ack_vld,
   input  logic                  ack_rdy,
   output logic [DATA_WIDTH-1:0] ack_rd_data,
   output logic                  ack_err,
   // APB initiator
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic                  PWRITE,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic [DATA_WIDTH-1:0] PWDATA,
   input  logic [DATA_WIDTH-1:0] PRDATA,
   input  logic                  PREADY,
   input  logic                  PSLVERR,
   // watchdog status
   input  logic                  clear,
   output logic                  interrupt,
   output logic [ADDR_WIDTH-1:0] to_addr
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic                  pwrite_q, pwrite_d;
   logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
   logic [DATA_WIDTH-1:0] ack_rd_data_q, ack_rd_data_d;
   logic                  ack_err_q, ack_err_d;

   // High on the ACCESS edge where the watchdog fires (never when PREADY=1).
   logic                  to_hit;

   // Read data returned for a timed-out transfer.
   localparam logic [DATA_WIDTH-1:0] TO_RD_DATA = DATA_WIDTH'(32'hdead_1eaf);

   // ------------------------------------------------------------------------
   // Watchdog
   // ------------------------------------------------------------------------
`ifdef APB_MST_BRIDGE_TIMEOUT_EN
   logic [15:0]           cnt_q, cnt_d;
   logic                  irq_q, irq_d;
   logic [ADDR_WIDTH-1:0] to_addr_q, to_addr_d;

   assign to_hit = (state_q == ST_ACCESS) && !PREADY && (cnt_q == 16'(TIMECNT));

   always_comb begin
      cnt_d     = cnt_q;
      irq_d     = irq_q;
      to_addr_d = to_addr_q;
      // Restart the count for every new transfer; count only wait states.
      if (state_q == ST_IDLE && req_vld) begin
         cnt_d = '0;
      end else if (state_q == ST_ACCESS && !PREADY && !to_hit) begin
         cnt_d = cnt_q + 16'd1;
      end
      if (clear) begin
         irq_d     = 1'b0;
         to_addr_d = '0;
      end
      // A timeout on the same edge as clear must not be lost.
      if (to_hit) begin
         irq_d     = 1'b1;
         to_addr_d = paddr_q;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q     <= '0;
         irq_q     <= 1'b0;
         to_addr_q <= '0;
      end else begin
         cnt_q     <= cnt_d;
         irq_q     <= irq_d;
         to_addr_q <= to_addr_d;
      end
   end

   assign interrupt = irq_q;
   assign to_addr   = to_addr_q;
`else
   logic unused_cfg;

   assign to_hit     = 1'b0;
   assign interrupt  = 1'b0;
   assign to_addr    = '0;
   assign unused_cfg = clear ^ (TIMECNT == 0);
`endif

   // ------------------------------------------------------------------------
   // Transfer FSM
   // ------------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      paddr_d       = paddr_q;
      pwrite_d      = pwrite_q;
      pwdata_d      = pwdata_q;
      ack_rd_data_d = ack_rd_data_q;
      ack_err_d     = ack_err_q;
      case (state_q)
         ST_IDLE: begin
            if (req_vld) begin
               paddr_d  = req_addr;
               pwrite_d = req_write;
               pwdata_d = req_wr_data;
               state_d  = ST_SETUP;
            end
         end
         ST_SETUP: begin
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (PREADY) begin
               ack_rd_data_d = pwrite_q ? '0 : PRDATA;
               ack_err_d     = PSLVERR;
               state_d       = ST_RESP;
            end else if (to_hit) begin
               ack_rd_data_d = TO_RD_DATA;
               ack_err_d     = 1'b1;
               state_d       = ST_RESP;
            end
         end
         ST_RESP: begin
            if (ack_rdy) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= ST_IDLE;
         paddr_q       <= '0;
         pwrite_q      <= 1'b0;
         pwdata_q      <= '0;
         ack_rd_data_q <= '0;
         ack_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         paddr_q       <= paddr_d;
         pwrite_q      <= pwrite_d;
         pwdata_q      <= pwdata_d;
         ack_rd_data_q <= ack_rd_data_d;
         ack_err_q     <= ack_err_d;
      end
   end

   // Handshake and APB strobes come straight from the state register, so
   // they are glitch-free and drop as soon as reset is asserted.
   assign req_rdy     = (state_q == ST_IDLE);
   assign PSEL        = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
   assign PENABLE     = (state_q == ST_ACCESS);
   assign ack_vld     = (state_q == ST_RESP);
   assign PADDR       = paddr_q;
   assign PWRITE      = pwrite_q;
   assign PWDATA      = pwdata_q;
   assign ack_rd_data = ack_rd_data_q;
   assign ack_err     = ack_err_q;

endmodule

// File: tb/tb_apb_mst_bridge.sv
// Self-checking bench for apb_mst_bridge: directed cases from the block's
// operating rules plus randomized transfers, each checked against expected
// latency, phase sequence and response values derived in the bench.
module tb_apb_mst_bridge;

`ifdef APB_MST_BRIDGE_TIMEOUT_EN
   localparam int TC = 4;
`else
   localparam int TC = 99;
`endif
   localparam logic [31:0] DEAD = 32'hdead_1eaf;
   localparam int NEVER = 100000;

   logic        clk = 1'b0;
   logic        rstn;
   logic        req_vld, req_rdy, req_write;
   logic [63:0] req_addr;
   logic [31:0] req_wr_data;
   logic        ack_vld, ack_rdy, ack_err;
   logic [31:0] ack_rd_data;
   logic [63:0] PADDR, to_addr;
   logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR;
   logic [31:0] PWDATA, PRDATA;
   logic        clear, interrupt;

   int n_chk = 0;
   int n_bad = 0;

   // reference state for the sticky watchdog outputs
   logic        exp_irq = 1'b0;
   logic [63:0] exp_to  = '0;

   apb_mst_bridge #(.ADDR_WIDTH(64), .DATA_WIDTH(32), .TIMECNT(TC)) dut (
      .clk(clk), .rstn(rstn),
      .req_vld(req_vld), .req_rdy(req_rdy), .req_addr(req_addr),
      .req_write(req_write), .req_wr_data(req_wr_data),
      .ack_vld(ack_vld), .ack_rdy(ack_rdy), .ack_rd_data(ack_rd_data),
      .ack_err(ack_err),
      .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .clear(clear), .interrupt(interrupt), .to_addr(to_addr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_sticky();
      chk("interrupt", interrupt, exp_irq);
      chk("to_addr", to_addr, exp_to);
   endtask

   // One complete transfer. 'waits' = ACCESS cycles with PREADY low before it
   // rises (NEVER = slave hung). 'bp' = cycles ack_rdy is held low in RESP.
   // 'clr_last' pulses clear during the final ACCESS cycle.
   task automatic xfer(input logic [63:0] addr, input logic wr, input logic [31:0] wd,
                       input int waits, input logic [31:0] rd, input logic err,
                       input int bp, input bit clr_last);
      bit          to;
      int          exp_lat, cyc, acc;
      logic [31:0] exp_data;
      logic        exp_err;
      // watchdog fires once more than TC wait states would be needed
      to       = (waits > TC);
      exp_lat  = to ? TC + 3 : waits + 3;
      exp_data = to ? DEAD : (wr ? 32'h0 : rd);
      exp_err  = to ? 1'b1 : err;

      chk("req_rdy_idle", req_rdy, 1'b1);
      req_vld     = 1'b1;
      req_addr    = addr;
      req_write   = wr;
      req_wr_data = wd;
      tick();
      // after acceptance the request lines may change freely
      req_vld     = 1'b0;
      req_addr    = {$urandom, $urandom};
      req_write   = 1'($urandom);
      req_wr_data = $urandom;

      cyc = 1;
      acc = 0;
      while (!ack_vld && cyc < 300) begin
         chk("psel", PSEL, 1'b1);
         chk("penable", PENABLE, (cyc >= 2) ? 1'b1 : 1'b0);
         chk("paddr", PADDR, addr);
         chk("pwrite", PWRITE, wr);
         chk("pwdata", PWDATA, wd);
         chk("req_rdy_busy", req_rdy, 1'b0);
         if (PENABLE) acc++;
         PREADY  = (cyc >= 2 + waits);
         PRDATA  = PREADY ? rd : $urandom;
         PSLVERR = PREADY ? err : 1'($urandom);
         ack_rdy = 1'($urandom);
         clear   = clr_last && (cyc == exp_lat - 1);
         tick();
         cyc++;
      end
      PREADY  = 1'b0;
      PSLVERR = 1'b0;
      clear   = 1'b0;
      if (to) begin
         exp_irq = 1'b1;
         exp_to  = addr;
      end else if (clr_last) begin
`ifdef APB_MST_BRIDGE_TIMEOUT_EN
         exp_irq = 1'b0;
         exp_to  = '0;
`endif
      end
      chk("latency", cyc, exp_lat);
      chk("access_cycles", acc, exp_lat - 2);

      for (int b = 0; b <= bp; b++) begin
         chk("ack_vld", ack_vld, 1'b1);
         chk("ack_rd_data", ack_rd_data, exp_data);
         chk("ack_err", ack_err, exp_err);
         chk("psel_resp", PSEL, 1'b0);
         chk("penable_resp", PENABLE, 1'b0);
         chk("req_rdy_resp", req_rdy, 1'b0);
         chk("paddr_hold", PADDR, addr);
         chk_sticky();
         ack_rdy = (b == bp);
         // a request presented while busy must be ignored
         req_vld = (b == bp) ? 1'b0 : 1'($urandom);
         PRDATA  = $urandom;
         tick();
      end
      ack_rdy = 1'b0;
      req_vld = 1'b0;
      chk("req_rdy_after", req_rdy, 1'b1);
      chk("ack_vld_after", ack_vld, 1'b0);
      chk("psel_after", PSEL, 1'b0);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
`ifdef APB_MST_BRIDGE_TIMEOUT_EN
      exp_irq = 1'b0;
      exp_to  = '0;
`endif
      chk_sticky();
   endtask

   task automatic chk_reset_outputs();
      chk("rst_psel", PSEL, 1'b0);
      chk("rst_penable", PENABLE, 1'b0);
      chk("rst_paddr", PADDR, 64'h0);
      chk("rst_pwrite", PWRITE, 1'b0);
      chk("rst_pwdata", PWDATA, 32'h0);
      chk("rst_ack_vld", ack_vld, 1'b0);
      chk("rst_ack_data", ack_rd_data, 32'h0);
      chk("rst_ack_err", ack_err, 1'b0);
      chk("rst_req_rdy", req_rdy, 1'b1);
      chk("rst_interrupt", interrupt, 1'b0);
      chk("rst_to_addr", to_addr, 64'h0);
   endtask

   initial begin
      rstn = 1'b0;
      req_vld = 1'b0; req_addr = '0; req_write = 1'b0; req_wr_data = '0;
      ack_rdy = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0; clear = 1'b0;
      #1;
      chk_reset_outputs();
      repeat (3) tick();
      rstn = 1'b1;
      tick();
      chk_reset_outputs();

      // zero-wait write
      xfer(64'h10, 1'b1, 32'ha5a5_5a5a, 0, 32'hffff_ffff, 1'b0, 0, 1'b0);
      // read with 3 wait states
      xfer(64'h20, 1'b0, 32'h0, 3, 32'h1234_5678, 1'b0, 0, 1'b0);
      // read with slave error: error flagged, watchdog untouched
      xfer(64'h24, 1'b0, 32'h0, 1, 32'hcafe_f00d, 1'b1, 0, 1'b0);
      // backpressure, then back-to-back requests
      xfer(64'h28, 1'b0, 32'h0, 0, 32'h0bad_beef, 1'b0, 5, 1'b0);
      xfer(64'h2c, 1'b1, 32'h5555_aaaa, 0, 32'h1111_2222, 1'b0, 0, 1'b0);
      xfer(64'h30, 1'b0, 32'h0, 0, 32'h3333_4444, 1'b0, 0, 1'b0);

      // randomized transfers (wait states stay below the watchdog limit)
      for (int i = 0; i < 40; i++) begin
         xfer({$urandom, $urandom}, 1'($urandom), $urandom,
              int'($urandom_range(0, 3)), $urandom, 1'($urandom),
              int'($urandom_range(0, 2)), 1'b0);
      end

`ifdef APB_MST_BRIDGE_TIMEOUT_EN
      // hung slave: TC+1 ACCESS cycles, then abort
      xfer(64'h40, 1'b0, 32'h0, NEVER, 32'h0, 1'b0, 0, 1'b0);
      do_clear();
      // timeout and clear on the same edge: set wins
      xfer(64'h44, 1'b1, 32'h9, NEVER, 32'h0, 1'b0, 1, 1'b1);
      do_clear();
      // PREADY on the would-be timeout edge: normal completion, no interrupt
      xfer(64'h48, 1'b0, 32'h0, TC, 32'h7777_8888, 1'b0, 0, 1'b0);
`else
      // clear has no effect without the watchdog
      do_clear();
`endif

      // asynchronous reset in the middle of ACCESS
      chk("req_rdy_pre_rst", req_rdy, 1'b1);
      req_vld = 1'b1; req_addr = 64'h60; req_write = 1'b1; req_wr_data = 32'h6;
      PREADY = 1'b0;
      tick();
      req_vld = 1'b0;
      tick();
      chk("penable_pre_rst", PENABLE, 1'b1);
      rstn = 1'b0;
      #1;
      chk_reset_outputs();
      exp_irq = 1'b0;
      exp_to  = '0;
      tick();
      rstn = 1'b1;
      tick();
      xfer(64'h64, 1'b0, 32'h0, 2, 32'hfeed_0001, 1'b0, 1, 1'b0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
